// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU queue drain: entry field geometry and the
// request FSM state encoding.
package lsu_pkg;

    // Queue entry layout, LSB first: addr, data, strb, we.
    localparam int ADDR_LSB = 0;

    function automatic int data_lsb(input int addr_w);
        return ADDR_LSB + addr_w;
    endfunction

    function automatic int strb_lsb(input int addr_w, input int data_w);
        return ADDR_LSB + addr_w + data_w;
    endfunction

    function automatic int we_bit(input int addr_w, input int data_w);
        return ADDR_LSB + addr_w + data_w + data_w / 8;
    endfunction

    // Field positions for the default 32-bit address / 32-bit data geometry.
    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;
    localparam int DATA_LSB   = data_lsb(LSU_ADDR_W);
    localparam int STRB_LSB   = strb_lsb(LSU_ADDR_W, LSU_DATA_W);
    localparam int WE_BIT     = we_bit(LSU_ADDR_W, LSU_DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_resp_tracker.sv
// Outstanding-transaction counter plus an in-order FIFO recording whether each
// accepted request was a load, so acks can be routed to the right response.
module lsu_resp_tracker #(
    parameter int MAX_OUTST = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           accept_i,
    input  logic                           accept_is_load_i,
    input  logic                           ack_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] count_o,
    output logic                           can_issue_o,
    output logic                           head_is_load_o,
    output logic                           ack_valid_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [MAX_OUTST-1:0] type_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // An ack with nothing outstanding is spurious and must not disturb state.
    assign ack_valid_o    = ack_i && (count_q != '0);
    assign head_is_load_o = type_q[rd_ptr_q];
    assign count_o        = count_q;

    always_comb begin
        count_d = count_q;
        if (accept_i && !ack_valid_o) begin
            count_d = count_q + 1'b1;
        end else if (!accept_i && ack_valid_o) begin
            count_d = count_q - 1'b1;
        end
    end

    // Issue decisions look at the post-update count so a freed slot is reused at once.
    assign can_issue_o = (count_d < CNT_W'(MAX_OUTST));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            type_q   <= '0;
        end else begin
            count_q <= count_d;
            if (accept_i) begin
                type_q[wr_ptr_q] <= accept_is_load_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (ack_valid_o) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

endmodule

// File: rtl/lsu_queue_drain.sv
// Drains the LSU request queue onto the data-memory bus and returns in-order
// load data / errors to writeback.
module lsu_queue_drain
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int ENTRY_W   = ADDR_W + DATA_W + DATA_W / 8 + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ENTRY_W-1:0]             q_data_i,
    input  logic                           q_valid_i,
    output logic                           q_pop_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_data_wr_o,
    output logic [DATA_W/8-1:0]            mem_wr_o,
    output logic                           mem_rd_o,
    input  logic                           mem_accept_i,
    input  logic                           mem_ack_i,
    input  logic [DATA_W-1:0]              mem_data_rd_i,
    input  logic                           mem_error_i,
    output logic                           resp_valid_o,
    output logic [DATA_W-1:0]              resp_data_o,
    output logic                           resp_error_o,
    output logic                           busy_o,
    output lsu_state_t                     dbg_state_o,
    output logic [$clog2(MAX_OUTST+1)-1:0] dbg_count_o
);

    // Handshakes: a request (mem_rd_o / nonzero mem_wr_o) is held with stable
    // addr/data until the cycle mem_accept_i is high; q_pop_o fires only while
    // q_valid_i is high; each accepted request gets exactly one in-order mem_ack_i.

    localparam int STRB_W = DATA_W / 8;
    localparam int D_LSB  = data_lsb(ADDR_W);
    localparam int S_LSB  = strb_lsb(ADDR_W, DATA_W);
    localparam int W_BIT  = we_bit(ADDR_W, DATA_W);

    lsu_state_t          state_q;
    lsu_state_t          state_d;
    logic                load_req;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [STRB_W-1:0]   strb_q;
    logic                rd_q;
    logic                resp_valid_q;
    logic                resp_error_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                accept_fire;
    logic                can_issue;
    logic                head_is_load;
    logic                ack_valid;
    logic [$clog2(MAX_OUTST+1)-1:0] count;

    assign accept_fire = (state_q == REQ) && mem_accept_i;

    lsu_resp_tracker #(
        .MAX_OUTST (MAX_OUTST)
    ) u_tracker (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .accept_i         (accept_fire),
        .accept_is_load_i (rd_q),
        .ack_i            (mem_ack_i),
        .count_o          (count),
        .can_issue_o      (can_issue),
        .head_is_load_o   (head_is_load),
        .ack_valid_o      (ack_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (q_valid_i) begin
                    if (can_issue) begin
                        load_req = 1'b1;
                        state_d  = REQ;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            REQ: begin
                if (mem_accept_i) begin
                    if (q_valid_i && can_issue) begin
                        load_req = 1'b1;
                    end else if (q_valid_i) begin
                        state_d = STALL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STALL: begin
                if (!q_valid_i) begin
                    state_d = IDLE;
                end else if (can_issue) begin
                    load_req = 1'b1;
                    state_d  = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
            rd_q   <= 1'b0;
        end else if (load_req) begin
            addr_q <= {q_data_i[ADDR_LSB+2 +: ADDR_W-2], 2'b00};
            data_q <= q_data_i[D_LSB +: DATA_W];
            strb_q <= q_data_i[S_LSB +: STRB_W];
            rd_q   <= ~q_data_i[W_BIT];
        end
    end

    // Store acks only surface an error pulse; load acks carry data to writeback.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= ack_valid && head_is_load;
            resp_error_q <= ack_valid && mem_error_i;
            if (ack_valid && head_is_load) begin
                resp_data_q <= mem_data_rd_i;
            end
        end
    end

    // Gated with reset so no pop can escape while the block is held in reset.
    assign q_pop_o       = load_req && rst_i;
    assign mem_addr_o    = addr_q;
    assign mem_data_wr_o = data_q;
    assign mem_rd_o      = (state_q == REQ) && rd_q;
    assign mem_wr_o      = ((state_q == REQ) && !rd_q) ? strb_q : '0;
    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign resp_error_o  = resp_error_q;
    assign busy_o        = (state_q != IDLE) || (count != '0);
    assign dbg_state_o   = state_q;
    assign dbg_count_o   = count;

endmodule
